// File: rtl/nspi_rx.sv
// nspi_rx: multi-channel SPI receiver (mode 0), far end of the nspi_tx link.
// Latency: rx_valid rises 5 clk cycles after the spi_clk rising edge of the last bit.
// Backpressure: one-frame output register; a frame completing while it is full and
//   rx_ready=0 is dropped and flagged on overrun.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   spi_clk, spi_mosi serial clock (idle low) and CHANNEL_NUMBER data lines, async to clk
//   data_out          CHANNEL_NUMBER received words, stable while rx_valid=1
//   rx_valid/rx_ready frame handshake to the consumer
//   overrun           1-cycle pulse, completed frame dropped because output was full
//   frame_error       1-cycle pulse, partial frame discarded by timeout
// Optional: define NSPI_RX_TIMEOUT_EN to enable the mid-frame idle timeout
//   (TIMEOUT_CYCLES); otherwise frame_error is tied 0 and partial frames wait forever.
module nspi_rx #(
  parameter int CHANNEL_NUMBER = 2,
  parameter int SPI_SIZE       = 8,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_clk,
  input  logic [CHANNEL_NUMBER-1:0] spi_mosi,
  output logic [SPI_SIZE-1:0]       data_out [CHANNEL_NUMBER],
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      overrun,
  output logic                      frame_error
);

  localparam int CW = (SPI_SIZE > 1) ? $clog2(SPI_SIZE) : 1;

  if (SPI_SIZE < 2 || CHANNEL_NUMBER < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("nspi_rx: illegal parameter value");
  end

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // sclk_q[0..1] is the 2-FF synchronizer, sclk_q[2] the delayed copy for edge detect.
  logic [2:0]                sclk_q;
  logic [CHANNEL_NUMBER-1:0] mosi_s1_q, mosi_s2_q;
  // Registered edge strobe and the mosi value captured alongside it, so data and
  // strobe stay aligned one stage after the synchronizers.
  logic                      samp_q;
  logic [CHANNEL_NUMBER-1:0] bit_q;
  state_t                    state_q;
  logic [CW-1:0]             bit_cnt_q;
  logic [SPI_SIZE-1:0]       shreg_q [CHANNEL_NUMBER];
  logic [SPI_SIZE-1:0]       shreg_d [CHANNEL_NUMBER];
  logic                      complete_q;
  logic [SPI_SIZE-1:0]       dout_q  [CHANNEL_NUMBER];
  logic                      valid_q, overrun_q, ferr_q;
`ifdef NSPI_RX_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0]            tcnt_q;
`endif

  always_comb begin
    for (int c = 0; c < CHANNEL_NUMBER; c++) begin
      shreg_d[c] = shreg_q[c];
      if (MSB_FIRST) shreg_d[c] = {shreg_q[c][SPI_SIZE-2:0], bit_q[c]};
      else           shreg_d[c] = {bit_q[c], shreg_q[c][SPI_SIZE-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q     <= '0;
      mosi_s1_q  <= '0;
      mosi_s2_q  <= '0;
      samp_q     <= 1'b0;
      bit_q      <= '0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      complete_q <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
      for (int c = 0; c < CHANNEL_NUMBER; c++) begin
        shreg_q[c] <= '0;
        dout_q[c]  <= '0;
      end
`ifdef NSPI_RX_TIMEOUT_EN
      tcnt_q     <= '0;
`endif
    end else begin
      sclk_q     <= {sclk_q[1:0], spi_clk};
      mosi_s1_q  <= spi_mosi;
      mosi_s2_q  <= mosi_s1_q;
      samp_q     <= sclk_q[1] & ~sclk_q[2];
      bit_q      <= mosi_s2_q;
      complete_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (samp_q) begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= CW'(1);
            state_q   <= ST_SHIFT;
`ifdef NSPI_RX_TIMEOUT_EN
            tcnt_q    <= '0;
`endif
          end
        end
        default: begin
          // An edge arriving in the timeout cycle takes priority over the timeout.
          if (samp_q) begin
            shreg_q <= shreg_d;
`ifdef NSPI_RX_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
            if (bit_cnt_q == CW'(SPI_SIZE - 1)) begin
              bit_cnt_q  <= '0;
              state_q    <= ST_IDLE;
              complete_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
`ifdef NSPI_RX_TIMEOUT_EN
          else if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
            tcnt_q    <= TCW'(TIMEOUT_CYCLES);
            bit_cnt_q <= '0;
            state_q   <= ST_IDLE;
            ferr_q    <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TCW'(1);
          end
`endif
        end
      endcase

      // Output stage: a consumer accept in the load cycle frees the slot for the new frame.
      if (complete_q) begin
        if (!valid_q || rx_ready) begin
          dout_q  <= shreg_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_out    = dout_q;
  assign rx_valid    = valid_q;
  assign overrun     = overrun_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_nspi_rx.sv
// Bench for nspi_rx: two instances (MSB-first and LSB-first) share all stimulus;
// expected frames go into per-instance queues and a negedge monitor pops them on
// every rx_valid & rx_ready, plus directed latency / reset / overrun checks.
module tb_nspi_rx;

  logic       clk, rst, spi_clk, rdy;
  logic [1:0] mosi;
  logic [7:0] d0 [2];
  logic [7:0] d1 [2];
  logic       v0, v1, ov0, ov1, fe0, fe1;

  int checks = 0, failures = 0;
  int cyc = 0, last_rise = 0;
  int ov_cnt0 = 0, ov_cnt1 = 0, fe_cnt0 = 0, fe_cnt1 = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  nspi_rx #(.CHANNEL_NUMBER(2), .SPI_SIZE(8), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(64)) u_msb (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(mosi), .data_out(d0),
    .rx_valid(v0), .rx_ready(rdy), .overrun(ov0), .frame_error(fe0));

  nspi_rx #(.CHANNEL_NUMBER(2), .SPI_SIZE(8), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(64)) u_lsb (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(mosi), .data_out(d1),
    .rx_valid(v1), .rx_ready(rdy), .overrun(ov1), .frame_error(fe1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // Scoreboard monitor: compare every accepted frame against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (v0 && rdy) begin
        if (q0.size() == 0) chk("msb unexpected frame", {16'h0, d0[1], d0[0]}, 32'hDEAD_BEEF);
        else begin
          logic [15:0] e;
          e = q0.pop_front();
          chk("msb data_out[0]", d0[0], e[7:0]);
          chk("msb data_out[1]", d0[1], e[15:8]);
        end
      end
      if (v1 && rdy) begin
        if (q1.size() == 0) chk("lsb unexpected frame", {16'h0, d1[1], d1[0]}, 32'hDEAD_BEEF);
        else begin
          logic [15:0] e;
          e = q1.pop_front();
          chk("lsb data_out[0]", d1[0], e[7:0]);
          chk("lsb data_out[1]", d1[1], e[15:8]);
        end
      end
      if (ov0) ov_cnt0++;
      if (ov1) ov_cnt1++;
      if (fe0) fe_cnt0++;
      if (fe1) fe_cnt1++;
    end
  end

  // One bit per channel, spi_clk period 8 clk; entered and left just after a posedge.
  task automatic sbit(input logic b0, input logic b1);
    mosi = {b1, b0};
    repeat (4) @(posedge clk);
    #1 spi_clk = 1'b1;
    last_rise = cyc;
    repeat (4) @(posedge clk);
    #1 spi_clk = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input int nbits, input bit push);
    if (push) begin
      q0.push_back({b, a});
      q1.push_back({rev8(b), rev8(a)});
    end
    for (int i = 7; i >= 8 - nbits; i--) sbit(a[i], b[i]);
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int n;
    n = 0;
    while (!v0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!v0) chk({nm, " rx_valid timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; spi_clk = 1'b0; mosi = 2'b00; rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset rx_valid", {v1, v0}, 2'b00);
    chk("reset overrun", {ov1, ov0}, 2'b00);
    chk("reset frame_error", {fe1, fe0}, 2'b00);
    chk("reset data msb", {d0[1], d0[0]}, 16'h0000);
    chk("reset data lsb", {d1[1], d1[0]}, 16'h0000);
    @(posedge clk); #1;

    // Basic frame; msb instance expects 0x0F/0xF0, lsb instance 0xF0/0x0F.
    send(8'h0F, 8'hF0, 8, 1'b1);
    begin
      int n;
      n = 0;
      while (!v0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("latency after last edge", cyc - last_rise, 32'd5);
      chk("lsb data_out[0] basic", d1[0], 8'hF0);
      @(negedge clk);
      chk("rx_valid single cycle", v0, 1'b0);
    end
    repeat (5) @(posedge clk); #1;

    // Overrun: second frame dropped while first is held.
    rdy = 1'b0;
    send(8'hBB, 8'hF0, 8, 1'b1);
    send(8'h11, 8'h22, 8, 1'b0);
    repeat (3) @(negedge clk);
    chk("overrun held data[0]", d0[0], 8'hBB);
    chk("overrun held data[1]", d0[1], 8'hF0);
    chk("overrun held valid", v0, 1'b1);
    chk("overrun pulse count", ov_cnt0, 32'd1);
    @(posedge clk); #1 rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("valid drops after drain", {v1, v0}, 2'b00);
    @(posedge clk); #1 rdy = 1'b0;

    // Back-to-back, rx_ready raised in the second frame's load cycle.
    send(8'hA5, 8'h5A, 8, 1'b1);
    send(8'h3C, 8'hC3, 8, 1'b1);
    rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("b2b valid held", v0, 1'b1);
    chk("b2b second frame data[0]", d0[0], 8'h3C);
    repeat (4) @(posedge clk); #1;

    // Reset drops a held frame and a partial frame.
    rdy = 1'b0;
    send(8'h55, 8'hAA, 8, 1'b0);
    send(8'hFF, 8'h00, 4, 1'b0);
    chk("held before reset", v0, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-reset valid", {v1, v0}, 2'b00);
    chk("post-reset data", {d0[1], d0[0]}, 16'h0000);
    @(posedge clk); #1 rdy = 1'b1;
    send(8'h81, 8'h7E, 8, 1'b1);
    wait_valid("after reset", 20);
    repeat (4) @(posedge clk); #1;

`ifdef NSPI_RX_TIMEOUT_EN
    // Partial frame abandoned by timeout, then a clean frame.
    send(8'hA0, 8'h40, 3, 1'b0);
    begin
      int fe_cyc;
      fe_cyc = -1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (fe0 && fe_cyc < 0) fe_cyc = cyc;
      end
      chk("timeout pulse cycle", fe_cyc - last_rise, 32'd68);
    end
    @(posedge clk); #1;
    send(8'hC3, 8'h3C, 8, 1'b1);
    wait_valid("after timeout", 20);
    repeat (4) @(posedge clk); #1;
    chk("frame_error count", fe_cnt0, 32'd1);
    chk("frame_error count lsb", fe_cnt1, 32'd1);
`else
    chk("frame_error count", fe_cnt0 + fe_cnt1, 32'd0);
`endif

    repeat (10) @(posedge clk);
    chk("msb queue drained", q0.size(), 32'd0);
    chk("lsb queue drained", q1.size(), 32'd0);
    chk("overrun total msb", ov_cnt0, 32'd1);
    chk("overrun total lsb", ov_cnt1, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
